hazard_stall_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage pipeline. Compares the D-stage source

---
 rtl/hazard_stall_ctrl_if.sv | 37 +++
 rtl/hazard_stall_ctrl.sv | 99 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bus: D-stage operand info, E/M producer info, MDU start
// controls, and the stall / MDU status returned by the controller.
// The controller connects through the slave modport; the pipeline side uses master.
interface hazard_stall_ctrl_if;
   logic [4:0]  D_rs;
   logic [4:0]  D_rt;
   logic [1:0]  D_rs_tuse;
   logic [1:0]  D_rt_tuse;
   logic        D_is_md;
   logic [4:0]  E_writeReg;
   logic [1:0]  E_tnew;
   logic [4:0]  M_writeReg;
   logic [1:0]  M_tnew;
   logic        E_md_start;
   logic        E_md_op;
   logic        F_stall;
   logic        D_stall;
   logic        E_flush;
   logic        md_busy;
   logic [3:0]  md_cnt;
   logic        md_done;
   logic [31:0] stall_cycles;

   modport master (
      output D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_is_md,
      output E_writeReg, E_tnew, M_writeReg, M_tnew,
      output E_md_start, E_md_op,
      input  F_stall, D_stall, E_flush, md_busy, md_cnt, md_done, stall_cycles
   );

   modport slave (
      input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_is_md,
      input  E_writeReg, E_tnew, M_writeReg, M_tnew,
      input  E_md_start, E_md_op,
      output F_stall, D_stall, E_flush, md_busy, md_cnt, md_done, stall_cycles
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Tuse/Tnew data-hazard detection against E and M producers, plus a busy
// counter for the multi-cycle multiply/divide unit.
// Optional macro HAZ_STATS_EN builds a saturating 32-bit stall-cycle counter;
// without it stall_cycles is tied to zero.
module hazard_stall_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   hazard_stall_ctrl_if.slave   bus
);

   // md_cnt is only 4 bits wide, so longer latencies cannot be represented.
   if (MULT_CYCLES < 1 || MULT_CYCLES > 15 || DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_cycles_check
      $error("hazard_stall_ctrl: MULT_CYCLES and DIV_CYCLES must be in 1..15");
   end

   logic       rs_stall;
   logic       rt_stall;
   logic       md_stall;
   logic       stall;
   logic [3:0] md_cnt;
   logic       md_busy;
   logic       md_done;

   // A source stalls when a producer with the same register will not be ready in time.
   function automatic logic src_hazard(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic [4:0] e_reg,
      input logic [1:0] e_tnew,
      input logic [4:0] m_reg,
      input logic [1:0] m_tnew
   );
      return (src != 5'd0) &&
             (((e_reg == src) && (e_tnew > tuse)) ||
              ((m_reg == src) && (m_tnew > tuse)));
   endfunction

   // Increment that holds at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] val);
      return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
   endfunction

   // Zero-latency stall decision from the current D/E/M state.
   always_comb begin
      rs_stall = src_hazard(bus.D_rs, bus.D_rs_tuse, bus.E_writeReg, bus.E_tnew,
                            bus.M_writeReg, bus.M_tnew);
      rt_stall = src_hazard(bus.D_rt, bus.D_rt_tuse, bus.E_writeReg, bus.E_tnew,
                            bus.M_writeReg, bus.M_tnew);
      md_stall = bus.D_is_md & (md_busy | bus.E_md_start);
      stall    = rs_stall | rt_stall | md_stall;
   end

   assign md_busy = (md_cnt != 4'd0);

   // MDU busy counter: loads on an accepted start, counts down to zero otherwise.
   // A start while busy is ignored; the pipeline never issues one because md_stall blocks it.
   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt  <= 4'd0;
         md_done <= 1'b0;
      end else begin
         if (bus.E_md_start && !md_busy) begin
            md_cnt <= bus.E_md_op ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
         end else if (md_busy) begin
            md_cnt <= md_cnt - 4'd1;
         end
         md_done <= (md_cnt == 4'd1);
      end
   end

`ifdef HAZ_STATS_EN
   logic [31:0] stall_cycles;

   // Count stalled cycles, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= 32'd0;
      end else if (stall) begin
         stall_cycles <= sat_inc(stall_cycles);
      end
   end

   assign bus.stall_cycles = stall_cycles;
`else
   assign bus.stall_cycles = 32'd0;
`endif

   assign bus.F_stall = stall;
   assign bus.D_stall = stall;
   assign bus.E_flush = stall;
   assign bus.md_busy = md_busy;
   assign bus.md_cnt  = md_cnt;
   assign bus.md_done = md_done;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a timestamp-based reference model.
module tb_hazard_stall_ctrl;
   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   hazard_stall_ctrl_if bus();

   hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the MDU is described by the edge number at which it goes idle.
   int     edge_no;
   int     mdl_end;
   int     mdl_done_edge;
   longint mdl_stats;

   function automatic int mdl_cnt();
      return (mdl_end > edge_no) ? (mdl_end - edge_no) : 0;
   endfunction

   function automatic bit mdl_src(input logic [4:0] src, input logic [1:0] tuse);
      if (src == 0) return 1'b0;
      if (src == bus.E_writeReg && int'(bus.E_tnew) > int'(tuse)) return 1'b1;
      if (src == bus.M_writeReg && int'(bus.M_tnew) > int'(tuse)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit mdl_stall();
      return mdl_src(bus.D_rs, bus.D_rs_tuse) || mdl_src(bus.D_rt, bus.D_rt_tuse) ||
             (bus.D_is_md && (mdl_cnt() > 0 || bus.E_md_start));
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_idle();
      bus.D_rs = 0; bus.D_rt = 0; bus.D_rs_tuse = 3; bus.D_rt_tuse = 3; bus.D_is_md = 0;
      bus.E_writeReg = 0; bus.E_tnew = 0; bus.M_writeReg = 0; bus.M_tnew = 0;
      bus.E_md_start = 0; bus.E_md_op = 0;
   endtask

   // One clock: check combinational outputs, advance the model, check registered outputs.
   task automatic cycle();
      bit s;
      #1;
      s = mdl_stall();
      chk("F_stall", bus.F_stall, s);
      chk("D_stall", bus.D_stall, s);
      chk("E_flush", bus.E_flush, s);
      if (reset) begin
         mdl_end = edge_no + 1;
         mdl_done_edge = -1;
         mdl_stats = 0;
      end else begin
         if (bus.E_md_start && mdl_cnt() == 0) begin
            mdl_end = edge_no + 1 + (bus.E_md_op ? DIV_N : MULT_N);
            mdl_done_edge = mdl_end;
         end
         if (s && mdl_stats < 64'hFFFF_FFFF) mdl_stats++;
      end
      @(posedge clk);
      edge_no++;
      #1;
      chk("md_cnt", bus.md_cnt, mdl_cnt());
      chk("md_busy", bus.md_busy, mdl_cnt() > 0);
      chk("md_done", bus.md_done, edge_no == mdl_done_edge);
`ifdef HAZ_STATS_EN
      chk("stall_cycles", bus.stall_cycles, mdl_stats);
`else
      chk("stall_cycles", bus.stall_cycles, 0);
`endif
      @(negedge clk);
   endtask

   initial begin
      int n_stall;
      int n_done;
      checks = 0; errors = 0;
      edge_no = 0; mdl_end = 0; mdl_done_edge = -1; mdl_stats = 0;
      set_idle();
      reset = 1'b1;
      cycle();
      cycle();
      chk("reset md_cnt", bus.md_cnt, 0);
      chk("reset md_busy", bus.md_busy, 0);
      chk("reset md_done", bus.md_done, 0);
      chk("reset stall_cycles", bus.stall_cycles, 0);
      reset = 1'b0;

      // Load-use: lw in E (tnew 2) feeding rs used in E (tuse 1).
      bus.E_writeReg = 8; bus.E_tnew = 2; bus.D_rs = 8; bus.D_rs_tuse = 1;
      #1 chk("lw-use stall", bus.F_stall, 1);
      cycle();
      bus.E_writeReg = 0; bus.E_tnew = 1; bus.M_writeReg = 8; bus.M_tnew = 1;
      #1 chk("lw-use resolved", bus.F_stall, 0);
      cycle();

      // Register 0 never stalls.
      set_idle();
      bus.D_rs = 0; bus.E_writeReg = 0; bus.E_tnew = 2; bus.D_rs_tuse = 0;
      #1 chk("reg0 no stall", bus.F_stall, 0);
      cycle();

      // beq needing rt in D while the M result is one cycle away.
      set_idle();
      bus.M_writeReg = 5; bus.M_tnew = 1; bus.D_rt = 5; bus.D_rt_tuse = 0;
      #1 chk("beq rt stall", bus.D_stall, 1);
      bus.D_rt_tuse = 1;
      #1 chk("rt tuse1 no stall", bus.D_stall, 0);
      cycle();

      // div start with an MD instruction waiting in D.
      set_idle();
      bus.D_is_md = 1; bus.E_md_start = 1; bus.E_md_op = 1;
      n_stall = 0; n_done = 0;
      #1 if (bus.F_stall === 1'b1) n_stall++;
      cycle();
      chk("div md_cnt load", bus.md_cnt, 10);
      bus.E_md_start = 0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (bus.F_stall !== 1'b1) break;
         n_stall++;
         cycle();
         if (bus.md_done === 1'b1) n_done++;
      end
      chk("div stall cycles", n_stall, 11);
      chk("div done pulses", n_done, 1);
      cycle();
      chk("done single pulse", bus.md_done, 0);

      // mult start then reset at md_cnt == 3.
      set_idle();
      bus.E_md_start = 1; bus.E_md_op = 0;
      cycle();
      chk("mult md_cnt load", bus.md_cnt, 5);
      bus.E_md_start = 0;
      cycle();
      cycle();
      chk("mult md_cnt 3", bus.md_cnt, 3);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("abort md_cnt", bus.md_cnt, 0);
      chk("abort md_busy", bus.md_busy, 0);

      // Exactly 7 stalled cycles after reset.
      set_idle();
      bus.E_writeReg = 8; bus.E_tnew = 2; bus.D_rs = 8; bus.D_rs_tuse = 1;
      for (int i = 0; i < 7; i++) cycle();
      set_idle();
      cycle();
`ifdef HAZ_STATS_EN
      chk("stats after 7", bus.stall_cycles, 7);
`else
      chk("stats disabled", bus.stall_cycles, 0);
`endif

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         reset          = ($urandom_range(0, 59) == 0);
         bus.D_rs       = 5'($urandom_range(0, 3));
         bus.D_rt       = 5'($urandom_range(0, 3));
         bus.D_rs_tuse  = 2'($urandom_range(0, 3));
         bus.D_rt_tuse  = 2'($urandom_range(0, 3));
         bus.D_is_md    = ($urandom_range(0, 2) == 0);
         bus.E_writeReg = 5'($urandom_range(0, 3));
         bus.E_tnew     = 2'($urandom_range(0, 3));
         bus.M_writeReg = 5'($urandom_range(0, 3));
         bus.M_tnew     = 2'($urandom_range(0, 3));
         bus.E_md_start = ($urandom_range(0, 7) == 0);
         bus.E_md_op    = 1'($urandom_range(0, 1));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
